// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz VGA timing constants, imported by the sync generator and the renderer.
// The optional divide-by-2 pixel enable is selected with the VGA_CLKDIV_EN macro in vga_sync.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int TICK_LINE = 481;

    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_sync_if.sv
// Pixel coordinate, blanking and sync bundle between vga_sync (master) and the renderer/connector (slave).
interface vga_sync_if;
    import vga_pkg::*;

    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   p_tick;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   frame_tick;

    modport master (
        output hsync, vsync, video_on, p_tick, pixel_x, pixel_y, frame_tick
    );

    modport slave (
        input hsync, vsync, video_on, p_tick, pixel_x, pixel_y, frame_tick
    );

endinterface

// File: rtl/vga_tick_div.sv
// Toggle divider: p_tick is high on every second clk, giving a 25 MHz pixel enable from 50 MHz.
module vga_tick_div (
    input  logic clk,
    input  logic rst,
    output logic p_tick
);

    logic div_q;
    logic div_d;

    always_comb begin
        div_d = ~div_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_d;
        end
    end

    assign p_tick = div_q;

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel counters, registered sync outputs and a one-clk frame_tick.
// Define VGA_CLKDIV_EN to divide a 50 MHz clk internally; otherwise clk is the 25 MHz pixel clock.
module vga_sync
    import vga_pkg::coord_t;
#(
    parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK,
    parameter int TICK_LINE = vga_pkg::TICK_LINE
) (
    input  logic       clk,
    input  logic       reset,
    vga_sync_if.master vga
);

    localparam coord_t H_MAX      = coord_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t V_MAX      = coord_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t H_VIS      = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS      = coord_t'(V_DISPLAY);
    localparam coord_t HS_START   = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_END     = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_START   = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_END     = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam coord_t TICK_V     = coord_t'(TICK_LINE);

    logic   p_tick;
    coord_t h_q, h_d;
    coord_t v_q, v_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   frame_tick_q, frame_tick_d;

`ifdef VGA_CLKDIV_EN
    vga_tick_div u_tick_div (
        .clk    (clk),
        .rst    (reset),
        .p_tick (p_tick)
    );
`else
    // Pixel clock supplied directly: enable is held high once out of reset.
    logic run_q;
    logic run_d;

    always_comb begin
        run_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run_d;
        end
    end

    assign p_tick = run_q;
`endif

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (p_tick) begin
            if (h_q == H_MAX) begin
                h_d = '0;
                v_d = (v_q == V_MAX) ? coord_t'(0) : v_q + coord_t'(1);
            end else begin
                h_d = h_q + coord_t'(1);
            end
        end
        // Syncs decode the next count so the registered outputs line up with the counters.
        hsync_d      = !((h_d >= HS_START) && (h_d <= HS_END));
        vsync_d      = !((v_d >= VS_START) && (v_d <= VS_END));
        frame_tick_d = p_tick && (h_d == '0) && (v_d == TICK_V);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q          <= '0;
            v_q          <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.video_on   = (h_q < H_VIS) && (v_q < V_VIS);
    assign vga.p_tick     = p_tick;
    assign vga.pixel_x    = h_q;
    assign vga.pixel_y    = v_q;
    assign vga.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: full 800-pixel lines with a shortened frame height to keep runs short.
`timescale 1ns/1ps
module tb_vga_sync;

    localparam int HD = 640, HF = 16, HS = 96, HB = 48;
    localparam int VD = 2, VF = 1, VS = 2, VB = 1, TL = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
`ifdef VGA_CLKDIV_EN
    localparam int CPP = 2;
`else
    localparam int CPP = 1;
`endif
    localparam int FRAME_CLKS = HT * VT * CPP;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    vga_sync_if vga_bus ();

    vga_sync #(
        .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .TICK_LINE (TL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vga   (vga_bus)
    );

    always #10 clk = ~clk;

    function automatic int px();
        return int'(vga_bus.pixel_x);
    endfunction

    function automatic int py();
        return int'(vga_bus.pixel_y);
    endfunction

    task automatic wait_pos(input int x, input int y);
        bit found = 1'b0;
        for (int k = 0; k < FRAME_CLKS + 8 && !found; k++) begin
            @(negedge clk);
            found = (px() == x) && (py() == y);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_pos: position (%0d,%0d) not reached, now at (%0d,%0d)", x, y, px(), py());
        end
    endtask

    task automatic test_reset();
        logic [24:0] obs;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        obs = {vga_bus.pixel_x, vga_bus.pixel_y, vga_bus.hsync, vga_bus.vsync,
               vga_bus.video_on, vga_bus.p_tick, vga_bus.frame_tick};
        n_checks++;
        if (obs !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, {10'd0, 10'd0, 5'b11100});
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (px() !== 0 || vga_bus.p_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL release_clk1: got x=%0d p_tick=%b expected x=0 p_tick=1", px(), vga_bus.p_tick);
        end
        @(negedge clk);
        n_checks++;
        if (px() !== 1 || vga_bus.p_tick !== ((CPP == 2) ? 1'b0 : 1'b1)) begin
            n_fail++;
            $display("FAIL release_clk2: got x=%0d p_tick=%b expected x=1 p_tick=%0d",
                     px(), vga_bus.p_tick, (CPP == 2) ? 0 : 1);
        end
        $display("test_reset done at t=%0t", $time);
    endtask

    task automatic test_line();
        int fall_x = -1, rise_x = -1, low_clks = 0;
        int prev_x = px(), prev_y = py();
        bit prev_h = vga_bus.hsync;
        bit wrapped = 1'b0, wrap_ok = 1'b0;
        for (int k = 0; k < 2 * HT * CPP && !wrapped; k++) begin
            @(negedge clk);
            if (prev_h && !vga_bus.hsync) fall_x = px();
            if (!prev_h && vga_bus.hsync) rise_x = px();
            if (!vga_bus.hsync) low_clks++;
            if (py() != prev_y) begin
                wrapped = 1'b1;
                wrap_ok = (prev_x == HT - 1) && (px() == 0) && (py() == prev_y + 1);
            end
            prev_h = vga_bus.hsync;
            prev_x = px();
            prev_y = py();
        end
        n_checks++;
        if (fall_x !== 656) begin
            n_fail++;
            $display("FAIL hsync_fall: got x=%0d expected 656", fall_x);
        end
        n_checks++;
        if (rise_x !== 752) begin
            n_fail++;
            $display("FAIL hsync_rise: got x=%0d expected 752", rise_x);
        end
        n_checks++;
        if (low_clks !== 96 * CPP) begin
            n_fail++;
            $display("FAIL hsync_width: got %0d clks expected %0d", low_clks, 96 * CPP);
        end
        n_checks++;
        if (!(wrapped && wrap_ok)) begin
            n_fail++;
            $display("FAIL line_wrap: got wrapped=%b ok=%b expected 1/1", wrapped, wrap_ok);
        end
        $display("test_line done: hsync %0d..%0d low %0d clks", fall_x, rise_x, low_clks);
    endtask

    task automatic test_frame();
        int vid_clks = 0, vid_bad = 0, vs_clks = 0, vs_bad = 0, ticks = 0, tick_ok = 0;
        int last_x = 0, last_y = 0;
        bit exp_vid;
        wait_pos(0, 0);
        for (int k = 0; k < FRAME_CLKS; k++) begin
            exp_vid = (px() < HD) && (py() < VD);
            if (vga_bus.video_on) vid_clks++;
            if (vga_bus.video_on !== exp_vid) vid_bad++;
            if (!vga_bus.vsync) begin
                vs_clks++;
                if (py() != VD + VF && py() != VD + VF + 1) vs_bad++;
            end
            if (vga_bus.frame_tick) begin
                ticks++;
                if (px() == 0 && py() == TL) tick_ok++;
            end
            last_x = px();
            last_y = py();
            @(negedge clk);
        end
        n_checks++;
        if (vid_clks !== HD * VD * CPP || vid_bad !== 0) begin
            n_fail++;
            $display("FAIL video_on: got %0d clks (%0d wrong) expected %0d", vid_clks, vid_bad, HD * VD * CPP);
        end
        n_checks++;
        if (vs_clks !== HT * VS * CPP || vs_bad !== 0) begin
            n_fail++;
            $display("FAIL vsync_window: got %0d clks (%0d outside) expected %0d", vs_clks, vs_bad, HT * VS * CPP);
        end
        n_checks++;
        if (ticks !== 1 || tick_ok !== 1) begin
            n_fail++;
            $display("FAIL frame_tick_count: got %0d pulses (%0d at (0,%0d)) expected 1", ticks, tick_ok, TL);
        end
        n_checks++;
        if (last_x !== HT - 1 || last_y !== VT - 1 || px() !== 0 || py() !== 0) begin
            n_fail++;
            $display("FAIL frame_wrap: got (%0d,%0d)->(%0d,%0d) expected (%0d,%0d)->(0,0)",
                     last_x, last_y, px(), py(), HT - 1, VT - 1);
        end
        $display("test_frame done: video_on %0d clks, vsync low %0d clks", vid_clks, vs_clks);
    endtask

    task automatic test_frame_period();
        int n = 0;
        bit seen = 1'b0;
        for (int k = 0; k < FRAME_CLKS + 8 && !seen; k++) begin
            @(negedge clk);
            seen = vga_bus.frame_tick;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL frame_tick_wait: got no pulse expected one within %0d clks", FRAME_CLKS);
        end
        @(negedge clk);
        n = 1;
        n_checks++;
        if (vga_bus.frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_tick_width: got %b on second clk expected 0", vga_bus.frame_tick);
        end
        while (!vga_bus.frame_tick && n <= FRAME_CLKS + 8) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n !== FRAME_CLKS) begin
            n_fail++;
            $display("FAIL frame_period: got %0d clks expected %0d", n, FRAME_CLKS);
        end
        $display("test_frame_period done: %0d clks", n);
    endtask

    task automatic test_pixel_rate();
        int bad = 0;
        bit exp_tick;
        wait_pos(100, 2);
        for (int k = 0; k < 20 * CPP; k++) begin
            exp_tick = (CPP == 1) ? 1'b1 : ((k % 2) == 1);
            if (vga_bus.p_tick !== exp_tick) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL p_tick_pattern: got %0d wrong samples expected 0", bad);
        end
        n_checks++;
        if (px() !== 120 || py() !== 2) begin
            n_fail++;
            $display("FAIL pixel_rate: got (%0d,%0d) expected (120,2)", px(), py());
        end
        $display("test_pixel_rate done at (%0d,%0d)", px(), py());
    endtask

    task automatic test_mid_reset();
        logic [24:0] obs;
        int ticks = 0, cnt = 0;
        bit seen = 1'b0;
        wait_pos(300, 1);
        #2 reset = 1'b1;
        #1;
        obs = {vga_bus.pixel_x, vga_bus.pixel_y, vga_bus.hsync, vga_bus.vsync,
               vga_bus.video_on, vga_bus.p_tick, vga_bus.frame_tick};
        n_checks++;
        if (obs !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", obs, {10'd0, 10'd0, 5'b11100});
        end
        repeat (3) begin
            @(negedge clk);
            if (vga_bus.frame_tick || px() != 0) ticks++;
        end
        n_checks++;
        if (ticks !== 0) begin
            n_fail++;
            $display("FAIL reset_hold: got %0d bad samples expected 0", ticks);
        end
        reset = 1'b0;
        for (int k = 0; k < TL * HT * CPP + 8 && !seen; k++) begin
            if (vga_bus.frame_tick) begin
                seen = 1'b1;
            end else begin
                if (vga_bus.p_tick) cnt++;
                @(negedge clk);
            end
        end
        n_checks++;
        if (!seen || cnt !== TL * HT) begin
            n_fail++;
            $display("FAIL restart_tick: got seen=%b after %0d p_ticks expected %0d", seen, cnt, TL * HT);
        end
        n_checks++;
        if (px() !== 0 || py() !== TL) begin
            n_fail++;
            $display("FAIL restart_pos: got (%0d,%0d) expected (0,%0d)", px(), py(), TL);
        end
        $display("test_mid_reset done: frame_tick after %0d p_ticks", cnt);
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_frame_period();
        test_pixel_rate();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
